uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Second-generation UART receiver peripheral on the PicoRV32 native memory bus. It adds several things to the single-byte receiver: a run-time programmable 16x oversampling baud generator, a parametrised receive FIFO, glitch-rejecting start detection, stop-bit checking with a framing-error flag, and a sticky overrun flag. Everything runs in the single system clock domain; there is no derived bit clock. It occupies one 16-byte window selected by `enable` from the top-level address decoder.

## Interface
- `DEFAULT_DIV`, 27: reset value of DIV, the number of clk cycles per oversample tick (50 MHz / (115200 × 16)).
- `FIFO_AW`, 4: FIFO address width; depth is 2^FIFO_AW entries.
- `clk` input 1: system clock, all logic on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `enable` input 1: block select from the address decoder.
- `mem_valid` input 1: PicoRV32 bus request.
- `mem_ready` output 1: single-cycle transaction acknowledge.
- `mem_instr` input 1: ignored.
- `mem_wstrb` input 4: byte write strobes; all-zero means a read.
- `mem_wdata` input 32: write data.
- `mem_addr` input 32: only bits [3:2] are decoded.
- `mem_rdata` output 32: registered read data; 0 when `enable` is low.
- `serial_in` input 1: asynchronous RX line, idle high.
- `irq_o` output 1: high while the FIFO is not empty or OVR is set.

## Operation
Register map, selected by `mem_addr[3:2]`:
- **0 DATA (read):** [7:0] byte, [8] E (FIFO empty), [9] FE, [10] PE. A read of a non-empty FIFO pops one entry. A read of an empty FIFO returns E=1 and [7:0]=0. Writes are ignored.
- **1 STATUS:**
  - Read: [FIFO_AW:0] fill level, [16] full, [17] OVR.
  - Write: a write with wdata[17]=1 clears OVR.
- **2 CTRL:**
  - [15:0] DIV, read/write. Written values of 0 and 1 both give 1 tick per clk.
  - [16] ODD parity select.
  - Any write to CTRL aborts the frame in progress and returns the FSM to IDLE.
- **3:** reads 0; writes are ignored.

Receive path:
- `serial_in` passes through a 2-flop synchroniser.
- The tick counter is 16 bits. It pulses `tick` when it reaches DIV−1, then wraps to 0.

FSM states (sample counter `sc` counts 0..15 on ticks):
- **IDLE:** on a synced falling edge, go to START with sc=0.
- **START:** at sc=7, if the line is still low, clear sc and go to DATA; otherwise return to IDLE (glitch rejection).
- **DATA:** sample the line when sc=15 (bit centre). Shift LSB first. After 8 bits go to PARITY if it is compiled in, else to STOP.
- **PARITY:** at sc=15, PE = (XOR of data) XOR line XOR ODD (even parity when ODD=0). Then go to STOP.
- **STOP:** at sc=15, FE = ~line. Push {PE, FE, data} into the FIFO and go to IDLE. If the line was low, IDLE still requires a new high-to-low edge before the next start.

FIFO rules:
- Push while full: the entry is dropped, OVR is set, and existing contents are unchanged.
- Push and pop in the same cycle while full: both succeed and OVR is not set.
- Push and pop in the same cycle while empty: the read returns E=1 and the pushed entry lands.
- Fill level saturates at 2^FIFO_AW. Pointers wrap modulo depth.

## Timing
- Bus handshake:
  - Cycle N: the block sees `mem_valid & enable & ~mem_ready`. At the end of cycle N, `mem_rdata` is loaded, the pop or register write takes effect, and `mem_ready` goes to 1.
  - Cycle N+1: `mem_ready` is high; it is low again in N+2. The latency is therefore exactly one cycle, and `mem_ready` is never high for two consecutive cycles.
- Input latency: a line edge is seen 2 clk after it arrives, because of the synchroniser.
- Push timing: the FIFO push occurs on the clk edge of the stop-bit sample tick. `irq_o` rises on the following cycle.
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, `irq_o`=0.
  - FIFO empty, OVR=0, DIV=DEFAULT_DIV, ODD=0, FSM=IDLE, counters 0, synchroniser flops=1.
- Reset asserted mid-frame discards the partial byte and the FIFO contents.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, the frame is 11 bits long, and CTRL[16] selects odd parity.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; the frame is 10 bits long.
  - PE always reads 0.
  - CTRL[16] reads 0 and writes to it are ignored.

## Test plan
- Reset, then read CTRL -> 0x0000001B. Read DATA -> 0x100. `mem_ready` pulses exactly one cycle after `mem_valid`.
- With DIV=4, send 0xA5 then 0x3C at 16×4 clk/bit -> STATUS level=2. Two DATA reads -> 0x0A5, then 0x03C. Third read -> 0x100.
- Glitch: hold `serial_in` low for 20 clk (<8 ticks at DIV=4) -> FSM returns to IDLE and FIFO level stays 0.
- Send 0x55 with the stop bit low -> DATA read = 0x255 (FE set).
- With FIFO_AW=2, send 5 bytes without reading -> full=1, OVR=1, first 4 bytes intact. Write STATUS with 0x20000 -> OVR=0.
- `UART_RX_PARITY_EN`, ODD=0: send 0x07 with parity bit 0 -> 0x407 (PE). Send 0x07 with parity bit 1 -> 0x007.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: PicoRV32 native bus slice with block select (master = CPU side, slave = peripheral)
interface uart_rx_fifo_if;
  logic        enable;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  modport master (output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
                  input mem_ready, mem_rdata);
  modport slave  (input enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling UART receiver with FIFO, FE/PE/OVR flags on the PicoRV32 bus
// Ports: clk, resetn (async active-low), bus (uart_rx_fifo_if.slave), serial_in (RX line), irq_o.
// Build option: define UART_RX_PARITY_EN to add a parity bit and CTRL[16] odd-parity select.
module uart_rx_fifo #(
  parameter int DEFAULT_DIV = 27,
  parameter int FIFO_AW     = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  uart_rx_fifo_if.slave        bus,
  input  logic                 serial_in,
  output logic                 irq_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  logic              s1, s2, rx_d, rx, fall;
  logic [15:0]       div, div_m1, tcnt;
  logic              tick;
  logic [2:0]        state, bc;
  logic [3:0]        sc;
  logic [7:0]        shreg;
  logic              pe_q, odd, ovr;
  logic [9:0]        mem [DEPTH];
  logic [9:0]        head;
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0]  level;
  logic              full, empty, acc, rd, wr, pop, push, do_push, ctrl_wr, stat_wr;
  logic [1:0]        reg_sel;
  logic [31:0]       rd_val;
  logic              unused;
  assign unused  = ^{bus.mem_instr, bus.mem_addr[31:4], bus.mem_addr[1:0], bus.mem_wdata[31:16]};
  assign rx      = s2;
  assign fall    = rx_d & ~rx;
  assign div_m1  = (div > 16'd1) ? div - 16'd1 : 16'd0;
  // >= so a DIV shrunk below the running count still wraps promptly
  assign tick    = tcnt >= div_m1;
  assign acc     = bus.mem_valid & bus.enable & ~bus.mem_ready;
  assign rd      = acc & ~|bus.mem_wstrb;
  assign wr      = acc & |bus.mem_wstrb;
  assign reg_sel = bus.mem_addr[3:2];
  assign ctrl_wr = wr & (reg_sel == 2'd2);
  assign stat_wr = wr & (reg_sel == 2'd1);
  assign empty   = level == '0;
  assign full    = level == (FIFO_AW+1)'(DEPTH);
  assign pop     = rd & (reg_sel == 2'd0) & ~empty;
  assign push    = (state == STOP) & tick & (sc == 4'd15) & ~ctrl_wr;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | pop);
  assign head    = mem[rp];
  assign irq_o   = ~empty | ovr;
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) odd <= 1'b0;
    else if (ctrl_wr) odd <= bus.mem_wdata[16];
`else
  assign odd = 1'b0;
`endif
  assign rd_val = (reg_sel == 2'd0) ? (empty ? 32'h100 : {21'b0, head[9:8], 1'b0, head[7:0]}) :
                  (reg_sel == 2'd1) ? {14'b0, ovr, full, 16'(level)} :
                  (reg_sel == 2'd2) ? {15'b0, odd, div} : 32'd0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      rx_d <= 1'b1;
      tcnt <= '0;
    end else begin
      s1   <= serial_in;
      s2   <= s1;
      rx_d <= s2;
      tcnt <= tick ? 16'd0 : tcnt + 16'd1;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      sc    <= '0;
      bc    <= '0;
      shreg <= '0;
      pe_q  <= 1'b0;
    end else if (ctrl_wr) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (fall) begin
          state <= START;
          sc    <= '0;
        end
        START: if (tick) begin
          sc <= sc + 4'd1;
          if (sc == 4'd7) begin
            sc    <= '0;
            bc    <= '0;
            state <= rx ? IDLE : DATA;
          end
        end
        DATA: if (tick) begin
          sc <= sc + 4'd1;
          if (sc == 4'd15) begin
            shreg <= {rx, shreg[7:1]};
            bc    <= bc + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bc == 3'd7) state <= PARITY;
`else
            if (bc == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tick) begin
          sc <= sc + 4'd1;
          if (sc == 4'd15) begin
            pe_q  <= ^shreg ^ rx ^ odd;
            state <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          sc <= sc + 4'd1;
          if (sc == 4'd15) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= {pe_q, ~rx, shreg};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp            <= '0;
      rp            <= '0;
      level         <= '0;
      ovr           <= 1'b0;
      div           <= 16'(DEFAULT_DIV);
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      wp            <= wp + FIFO_AW'(do_push);
      rp            <= rp + FIFO_AW'(pop);
      level         <= level + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(pop);
      ovr           <= (ovr & ~(stat_wr & bus.mem_wdata[17])) | (push & full & ~pop);
      div           <= ctrl_wr ? bus.mem_wdata[15:0] : div;
      bus.mem_ready <= acc;
      bus.mem_rdata <= acc ? rd_val : 32'd0;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (FIFO_AW=2, DIV=4 for frames)
module tb_uart_rx_fifo;
  localparam int BIT_CLKS = 64;
  logic clk = 1'b0, resetn = 1'b0, serial_in = 1'b1, irq_o;
  int checks = 0, errors = 0;
  uart_rx_fifo_if bus();
  uart_rx_fifo #(.FIFO_AW(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .serial_in(serial_in), .irq_o(irq_o)
  );
  always #5 clk = ~clk;

  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          output logic [31:0] rdv, output int lat);
    @(negedge clk);
    bus.enable = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = addr;
    bus.mem_wstrb = wstrb; bus.mem_wdata = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.mem_ready && lat < 8);
    if (!bus.mem_ready) lat = 99;
    rdv = bus.mem_rdata;
    bus.enable = 1'b0; bus.mem_valid = 1'b0; bus.mem_wstrb = 4'b0;
  endtask

  task automatic line_bit(input logic v);
    serial_in = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    line_bit(par);
`endif
    line_bit(stop);
    serial_in = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    int lat;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'd0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rdata=%h irq=%b exp 0 0 0", bus.mem_ready, bus.mem_rdata, irq_o);
    end
    resetn = 1'b1;
    bus_xfer(32'h8, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h1B) begin errors++; $display("FAIL reset_ctrl got %h exp 0000001b", r); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL ready_latency got %0d exp 1", lat); end
    @(negedge clk);
    checks++;
    if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL ready_pulse got %b exp 0", bus.mem_ready); end
    checks++;
    if (bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL rdata_idle got %h exp 0", bus.mem_rdata); end
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h100) begin errors++; $display("FAIL reset_data got %h exp 00000100", r); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] seen;
    @(negedge clk);
    bus.enable = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = 32'h8; bus.mem_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[i] = bus.mem_ready;
    end
    bus.enable = 1'b0; bus.mem_valid = 1'b0;
    checks++;
    if (seen !== 4'b0101) begin errors++; $display("FAIL ready_pattern got %b exp 0101", seen); end
  endtask

  task automatic test_basic;
    logic [31:0] r;
    int lat;
    bus_xfer(32'h8, 4'hF, 32'h4, r, lat);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL basic_irq got %b exp 1", irq_o); end
    bus_xfer(32'h4, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL basic_level got %h exp 00000002", r); end
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0A5) begin errors++; $display("FAIL basic_first got %h exp 000000a5", r); end
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h03C) begin errors++; $display("FAIL basic_second got %h exp 0000003c", r); end
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h100) begin errors++; $display("FAIL basic_empty got %h exp 00000100", r); end
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL basic_irq_clear got %b exp 0", irq_o); end
  endtask

  task automatic test_glitch;
    logic [31:0] r;
    int lat;
    serial_in = 1'b0;
    repeat (20) @(negedge clk);
    serial_in = 1'b1;
    repeat (200) @(negedge clk);
    bus_xfer(32'h4, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL glitch_level got %h exp 00000000", r); end
    send_frame(8'h81, 1'b0, 1'b1);
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h081) begin errors++; $display("FAIL glitch_after got %h exp 00000081", r); end
  endtask

  task automatic test_framing;
    logic [31:0] r;
    int lat;
    send_frame(8'h55, 1'b0, 1'b0);
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h255) begin errors++; $display("FAIL framing got %h exp 00000255", r); end
    send_frame(8'h18, 1'b0, 1'b1);
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h018) begin errors++; $display("FAIL framing_recover got %h exp 00000018", r); end
  endtask

  task automatic test_overrun;
    logic [31:0] r;
    logic [7:0] vals [5];
    int lat;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_frame(vals[i], 1'b0, 1'b1);
    bus_xfer(32'h4, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h30004) begin errors++; $display("FAIL ovr_status got %h exp 00030004", r); end
    bus_xfer(32'h4, 4'hF, 32'h20000, r, lat);
    bus_xfer(32'h4, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h10004) begin errors++; $display("FAIL ovr_clear got %h exp 00010004", r); end
    for (int i = 0; i < 4; i++) begin
      bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
      checks++;
      if (r !== {24'h0, vals[i]}) begin errors++; $display("FAIL ovr_data%0d got %h exp %h", i, r, {24'h0, vals[i]}); end
    end
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h100) begin errors++; $display("FAIL ovr_empty got %h exp 00000100", r); end
  endtask

  task automatic test_parity;
    logic [31:0] r;
    int lat;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h407) begin errors++; $display("FAIL parity_bad got %h exp 00000407", r); end
    send_frame(8'h07, 1'b1, 1'b1);
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h007) begin errors++; $display("FAIL parity_good got %h exp 00000007", r); end
    bus_xfer(32'h8, 4'hF, 32'h10004, r, lat);
    bus_xfer(32'h8, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h10004) begin errors++; $display("FAIL parity_ctrl got %h exp 00010004", r); end
    send_frame(8'h07, 1'b0, 1'b1);
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h007) begin errors++; $display("FAIL parity_odd got %h exp 00000007", r); end
`else
    bus_xfer(32'h8, 4'hF, 32'h10004, r, lat);
    bus_xfer(32'h8, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h4) begin errors++; $display("FAIL noparity_ctrl got %h exp 00000004", r); end
    send_frame(8'h07, 1'b0, 1'b1);
    bus_xfer(32'h0, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h007) begin errors++; $display("FAIL noparity_data got %h exp 00000007", r); end
`endif
    bus_xfer(32'h8, 4'hF, 32'h4, r, lat);
  endtask

  task automatic test_reg3;
    logic [31:0] r;
    int lat;
    bus_xfer(32'hC, 4'hF, 32'hFFFF_FFFF, r, lat);
    bus_xfer(32'hC, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reg3 got %h exp 00000000", r); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] r;
    int lat;
    send_frame(8'h5A, 1'b0, 1'b1);
    serial_in = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    serial_in = 1'b1;
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b exp 0", irq_o); end
    bus_xfer(32'h4, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL midreset_level got %h exp 00000000", r); end
    bus_xfer(32'h8, 4'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h1B) begin errors++; $display("FAIL midreset_ctrl got %h exp 0000001b", r); end
  endtask

  initial begin
    bus.enable = 1'b0; bus.mem_valid = 1'b0; bus.mem_instr = 1'b0;
    bus.mem_wstrb = 4'h0; bus.mem_wdata = 32'h0; bus.mem_addr = 32'h0;
    test_reset();
    test_back_to_back();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_parity();
    test_reg3();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
